lcg_stim_gen: RTL



---
 rtl/lcg_stim_gen.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/lcg_stim_gen.sv
// lcg_stim_gen: deterministic pseudo-random vector source built on a 32-bit LCG.
// Each vector is assembled from ceil(OUT_W/32) consecutive LCG outputs, least
// significant word first, so it matches a software generator word for word.
// Vectors are handed to the consumer over a valid/ready handshake, either for a
// fixed run length or forever (num_vec == 0).
module lcg_stim_gen #(
    parameter int          OUT_W   = 141,
    parameter logic [31:0] LCG_MUL = 32'h41C64E6D,
    parameter logic [31:0] LCG_INC = 32'h00003039,
    parameter int          CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [31:0]      seed,
    input  logic [CNT_W-1:0] num_vec,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] vec_count,
    output logic [31:0]      rng_state
);

    localparam int NW    = (OUT_W + 31) / 32;
    localparam int IDX_W = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NW - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FILL    = 2'd1,
        ST_PRESENT = 2'd2
    } state_t;

    // One LCG step, modulo 2^32 by truncation to the 32-bit result.
    function automatic logic [31:0] lcg_step(input logic [31:0] cur);
        lcg_step = cur * LCG_MUL + LCG_INC;
    endfunction

    state_t              state_r;
    state_t              state_nx_s;
    logic [31:0]         rng_r;
    logic [31:0]         rng_next_s;
    logic [IDX_W-1:0]    word_idx_r;
    logic [NW*32-1:0]    stage_r;
    logic [NW*32-1:0]    stage_s;
    logic [CNT_W-1:0]    run_len_r;
    logic [CNT_W-1:0]    vec_count_r;
    logic [CNT_W-1:0]    vec_count_inc_s;
    logic [OUT_W-1:0]    out_data_r;
    logic                out_valid_r;
    logic                busy_r;
    logic                done_r;
    logic                last_word_s;
    logic                last_vec_s;

    // Datapath helpers: next LCG value, staging with the current word merged, end-of-fill/run flags.
    always_comb begin
        rng_next_s      = lcg_step(rng_r);
        vec_count_inc_s = vec_count_r + CNT_W'(1);
        last_word_s     = (word_idx_r == LAST_IDX);
        last_vec_s      = (run_len_r != {CNT_W{1'b0}}) && (vec_count_inc_s == run_len_r);
        stage_s         = stage_r;
        for (int j = 0; j < NW; j++) begin
            if (word_idx_r == IDX_W'(j)) begin
                stage_s[j*32 +: 32] = rng_next_s;
            end else begin
                stage_s[j*32 +: 32] = stage_r[j*32 +: 32];
            end
        end
    end

    // Next-state decode; abort overrides every other transition out of any state.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (abort) begin
                    state_nx_s = ST_IDLE;
                end else if (start) begin
                    state_nx_s = ST_FILL;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (abort) begin
                    state_nx_s = ST_IDLE;
                end else if (last_word_s) begin
                    state_nx_s = ST_PRESENT;
                end else begin
                    state_nx_s = ST_FILL;
                end
            end
            ST_PRESENT: begin
                if (abort) begin
                    state_nx_s = ST_IDLE;
                end else if (out_ready) begin
                    state_nx_s = last_vec_s ? ST_IDLE : ST_FILL;
                end else begin
                    state_nx_s = ST_PRESENT;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Datapath registers: seed capture, word fill, vector presentation and run accounting.
    always_ff @(posedge clk) begin
        if (rst) begin
            rng_r       <= 32'h0000_0000;
            word_idx_r  <= {IDX_W{1'b0}};
            stage_r     <= {(NW*32){1'b0}};
            run_len_r   <= {CNT_W{1'b0}};
            vec_count_r <= {CNT_W{1'b0}};
            out_data_r  <= {OUT_W{1'b0}};
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            busy_r <= (state_nx_s != ST_IDLE);
            case (state_r)
                ST_IDLE: begin
                    if (!abort && start) begin
                        rng_r       <= seed;
                        run_len_r   <= num_vec;
                        vec_count_r <= {CNT_W{1'b0}};
                        word_idx_r  <= {IDX_W{1'b0}};
                    end else begin
                        rng_r <= rng_r;
                    end
                end
                ST_FILL: begin
                    if (!abort) begin
                        rng_r   <= rng_next_s;
                        stage_r <= stage_s;
                        if (last_word_s) begin
                            out_data_r  <= stage_s[OUT_W-1:0];
                            out_valid_r <= 1'b1;
                            word_idx_r  <= {IDX_W{1'b0}};
                        end else begin
                            word_idx_r  <= word_idx_r + IDX_W'(1);
                        end
                    end else begin
                        word_idx_r <= {IDX_W{1'b0}};
                    end
                end
                ST_PRESENT: begin
                    if (abort) begin
                        out_valid_r <= 1'b0;
                    end else if (out_ready) begin
                        vec_count_r <= vec_count_inc_s;
                        out_valid_r <= 1'b0;
                        done_r      <= last_vec_s;
                    end else begin
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign vec_count = vec_count_r;
    assign rng_state = rng_r;

endmodule
